// File: rtl/polynomial_encoder_pkg.sv
// Shared constants and types for the NewHope polynomial byte packer.
package polynomial_encoder_pkg;

  localparam int Q          = 12289;
  localparam int N          = 512;
  localparam int NBYTES     = 896;
  localparam int COEF_BITS  = 14;
  localparam int PACK_GROUP = 4;
  localparam int PACK_BYTES = 7;
  localparam int NGROUPS    = N / PACK_GROUP;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_LAST,
    ST_WR
  } enc_state_e;

endpackage

// File: rtl/polynomial_encoder_coeff_freeze.sv
// Brings a coefficient below 2Q into [0,Q) with one conditional subtract; 14-bit result.
module coeff_freeze
  import polynomial_encoder_pkg::*;
(
  input  logic [15:0]          coeff,
  output logic [COEF_BITS-1:0] frozen
);

  logic ge_q;

  assign ge_q = (coeff >= 16'(Q));
  // Q fits in 14 bits, so the low bits of the difference need only the low input bits.
  assign frozen = ge_q ? (coeff[COEF_BITS-1:0] - COEF_BITS'(Q)) : coeff[COEF_BITS-1:0];

endmodule

// File: rtl/polynomial_encoder.sv
// Serialises 512 coefficients into 896 bytes, four 14-bit values per seven bytes.
//   state   | meaning
//   IDLE    | waiting for start
//   RD      | issue reads 4g..4g+3 (rd_idx), capture previous read data
//   LAST    | capture fourth coefficient, present byte 0 of the group
//   WR      | present bytes 1..6 (wr_idx), then next group or finish
module polynomial_encoder
  import polynomial_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic [8:0]  addr_in,
  input  logic [15:0] din,
  output logic        we_out,
  output logic [9:0]  addr_out,
  output logic [7:0]  dout
);

  enc_state_e     state;
  logic [1:0]     rd_idx;
  logic [2:0]     wr_idx;
  logic [6:0]     group;
  logic [55:0]    pack;
  logic [13:0]    t_frz;
  logic [55:0]    pack_cap;
  logic [9:0]     wr_base;

  coeff_freeze u_freeze (
    .coeff  (din),
    .frozen (t_frz)
  );

  // New coefficients enter at the top, so after four captures t0 sits in bits 13:0.
  assign pack_cap = {t_frz, pack[55:14]};
  assign wr_base  = {group, 3'b000} - {3'b000, group};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rd_idx   <= '0;
      wr_idx   <= '0;
      group    <= '0;
      pack     <= '0;
      done     <= 1'b0;
      we_out   <= 1'b0;
      addr_in  <= '0;
      addr_out <= '0;
      dout     <= '0;
    end else begin
      done   <= 1'b0;
      we_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RD;
            rd_idx  <= '0;
            group   <= '0;
            addr_in <= '0;
          end
        end
        ST_RD: begin
          if (rd_idx != 2'd0) pack <= pack_cap;
          if (rd_idx == 2'd3) state <= ST_LAST;
          else                addr_in <= addr_in + 9'd1;
          rd_idx <= rd_idx + 2'd1;
        end
        ST_LAST: begin
          pack     <= pack_cap >> 8;
          dout     <= pack_cap[7:0];
          we_out   <= 1'b1;
          addr_out <= wr_base;
          wr_idx   <= '0;
          state    <= ST_WR;
        end
        ST_WR: begin
          if (wr_idx == 3'd6) begin
            addr_in <= addr_in + 9'd1;
            group   <= group + 7'd1;
            rd_idx  <= '0;
            if (group == 7'(NGROUPS - 1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              state <= ST_RD;
            end
          end else begin
            we_out   <= 1'b1;
            dout     <= pack[7:0];
            pack     <= pack >> 8;
            addr_out <= addr_out + 10'd1;
            wr_idx   <= wr_idx + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polynomial_encoder.sv
// Directed bench for polynomial_encoder: RAM model, write monitor and byte-exact packing model.
module tb_polynomial_encoder;
  import polynomial_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done;
  logic [8:0]  addr_in;
  logic [15:0] din;
  logic        we_out;
  logic [9:0]  addr_out;
  logic [7:0]  dout;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:511];
  logic [7:0]  got [0:895];
  int edge_cnt = 0;
  int t_start = 0;
  int wr_cnt, done_cnt, done_tag, first_tag, last_tag, tim_err;

  polynomial_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .done     (done),
    .addr_in  (addr_in),
    .din      (din),
    .we_out   (we_out),
    .addr_out (addr_out),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    din      <= mem[addr_in];
  end

  // Observes outputs 1 time unit after each edge; edge_cnt then equals the cycle index.
  always begin
    @(posedge clk);
    #1;
    if (we_out === 1'b1) begin
      got[addr_out] = dout;
      if (wr_cnt == 0) first_tag = edge_cnt;
      last_tag = edge_cnt;
      if (edge_cnt != t_start + 6 + 12 * (int'(addr_out) / 7) + int'(addr_out) % 7)
        tim_err++;
      wr_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_tag = edge_cnt;
    end
  end

  function automatic logic [13:0] frz(logic [15:0] c);
    logic [15:0] d;
    d = c - 16'd12289;
    if (c >= 16'd12289) return d[13:0];
    return c[13:0];
  endfunction

  function automatic logic [7:0] exp_byte(int k);
    logic [55:0] p;
    int g, j;
    g = k / 7;
    j = k % 7;
    for (int i = 0; i < 4; i++) p[14*i +: 14] = frz(mem[4*g + i]);
    return p[8*j +: 8];
  endfunction

  function automatic int byte_errs();
    int n;
    n = 0;
    for (int k = 0; k < NBYTES; k++) if (got[k] !== exp_byte(k)) n++;
    return n;
  endfunction

  task automatic clear_mon();
    wr_cnt = 0; done_cnt = 0; tim_err = 0;
    first_tag = -1; last_tag = -1; done_tag = -1;
    for (int k = 0; k < NBYTES; k++) got[k] = 'x;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = 16'($urandom_range(0, 2*Q - 1));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    t_start = edge_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (we_out !== 1'b0)    begin errors++; $display("FAIL reset_we got %b expected 0", we_out); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (addr_in !== 9'd0)   begin errors++; $display("FAIL reset_addr_in got %0d expected 0", addr_in); end
    checks++; if (addr_out !== 10'd0) begin errors++; $display("FAIL reset_addr_out got %0d expected 0", addr_out); end
    checks++; if (dout !== 8'd0)      begin errors++; $display("FAIL reset_dout got %0h expected 0", dout); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    bit ok;
    int n;
    for (int i = 0; i < N; i++) mem[i] = 16'd0;
    clear_mon();
    pulse_start();
    wait_done(2000, ok);
    repeat (4) @(negedge clk);
    n = byte_errs();
    checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got no done expected done"); end
    checks++; if (wr_cnt != 896) begin errors++; $display("FAIL zero_writes got %0d expected 896", wr_cnt); end
    checks++; if (first_tag != t_start + 6) begin errors++; $display("FAIL zero_first got %0d expected %0d", first_tag, t_start + 6); end
    checks++; if (last_tag != t_start + 1536) begin errors++; $display("FAIL zero_last got %0d expected %0d", last_tag, t_start + 1536); end
    checks++; if (done_tag != t_start + 1537) begin errors++; $display("FAIL zero_done_time got %0d expected %0d", done_tag, t_start + 1537); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got %0d expected 1", done_cnt); end
    checks++; if (tim_err != 0) begin errors++; $display("FAIL zero_write_timing got %0d expected 0", tim_err); end
    checks++; if (n != 0) begin errors++; $display("FAIL zero_bytes got %0d bad expected 0", n); end
  endtask

  task automatic test_ramp();
    bit ok;
    int n;
    logic [7:0] g0 [0:6];
    g0 = '{8'h00, 8'h40, 8'h00, 8'h20, 8'h00, 8'h0C, 8'h00};
    for (int i = 0; i < N; i++) mem[i] = 16'(i);
    clear_mon();
    pulse_start();
    wait_done(2000, ok);
    n = byte_errs();
    checks++; if (!ok) begin errors++; $display("FAIL ramp_timeout got no done expected done"); end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got[k] !== g0[k]) begin errors++; $display("FAIL ramp_b%0d got %0h expected %0h", k, got[k], g0[k]); end
    end
    checks++; if (n != 0) begin errors++; $display("FAIL ramp_bytes got %0d bad expected 0", n); end
    checks++; if (wr_cnt != 896) begin errors++; $display("FAIL ramp_writes got %0d expected 896", wr_cnt); end
  endtask

  task automatic test_reduce();
    bit ok;
    logic [7:0] g0 [0:6];
    // t = {0, 12288, 12288, 0}: only t1[13:12] and t2[13:12] are set.
    g0 = '{8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00};
    for (int i = 0; i < N; i++) mem[i] = 16'd0;
    mem[0] = 16'd12289;
    mem[1] = 16'd12288;
    mem[2] = 16'd24577;
    mem[3] = 16'd0;
    clear_mon();
    pulse_start();
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reduce_timeout got no done expected done"); end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got[k] !== g0[k]) begin errors++; $display("FAIL reduce_b%0d got %0h expected %0h", k, got[k], g0[k]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    fill_random();
    clear_mon();
    pulse_start();
    for (int r = 0; r < 3; r++) begin
      wait_done(2000, ok);
      n = byte_errs();
      checks++; if (!ok) begin errors++; $display("FAIL b2b%0d_timeout got no done expected done", r); end
      checks++; if (wr_cnt != 896) begin errors++; $display("FAIL b2b%0d_writes got %0d expected 896", r, wr_cnt); end
      checks++; if (done_tag != t_start + 1537) begin errors++; $display("FAIL b2b%0d_done_time got %0d expected %0d", r, done_tag, t_start + 1537); end
      checks++; if (tim_err != 0) begin errors++; $display("FAIL b2b%0d_write_timing got %0d expected 0", r, tim_err); end
      checks++; if (n != 0) begin errors++; $display("FAIL b2b%0d_bytes got %0d bad expected 0", r, n); end
      if (r < 2) begin
        clear_mon();
        fill_random();
        start = 1'b1;
        t_start = edge_cnt;
        @(negedge clk);
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n, w_at_rst;
    fill_random();
    clear_mon();
    pulse_start();
    for (int i = 0; i < 2000 && edge_cnt < t_start + 700; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (we_out !== 1'b0)    begin errors++; $display("FAIL rstmid_we got %b expected 0", we_out); end
    checks++; if (addr_out !== 10'd0) begin errors++; $display("FAIL rstmid_addr_out got %0d expected 0", addr_out); end
    checks++; if (addr_in !== 9'd0)   begin errors++; $display("FAIL rstmid_addr_in got %0d expected 0", addr_in); end
    rst = 1'b0;
    w_at_rst = wr_cnt;
    repeat (1000) @(negedge clk);
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done got %0d expected 0", done_cnt); end
    checks++; if (wr_cnt != w_at_rst) begin errors++; $display("FAIL rstmid_idle_writes got %0d expected %0d", wr_cnt, w_at_rst); end
    clear_mon();
    pulse_start();
    wait_done(2000, ok);
    n = byte_errs();
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got no done expected done"); end
    checks++; if (done_tag != t_start + 1537) begin errors++; $display("FAIL rstmid_done_time got %0d expected %0d", done_tag, t_start + 1537); end
    checks++; if (n != 0) begin errors++; $display("FAIL rstmid_bytes got %0d bad expected 0", n); end
  endtask

  task automatic test_start_spam();
    bit seen;
    int n;
    fill_random();
    clear_mon();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      start = (edge_cnt < t_start + 1500) && (edge_cnt % 37 == 0);
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    n = byte_errs();
    checks++; if (!seen) begin errors++; $display("FAIL spam_timeout got no done expected done"); end
    checks++; if (wr_cnt != 896) begin errors++; $display("FAIL spam_writes got %0d expected 896", wr_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL spam_done_count got %0d expected 1", done_cnt); end
    checks++; if (done_tag != t_start + 1537) begin errors++; $display("FAIL spam_done_time got %0d expected %0d", done_tag, t_start + 1537); end
    checks++; if (n != 0) begin errors++; $display("FAIL spam_bytes got %0d bad expected 0", n); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 16'd0;
    clear_mon();
    test_reset();
    test_zero();
    test_ramp();
    test_reduce();
    test_back_to_back();
    test_reset_mid();
    test_start_spam();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
